// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - n-th term of Fibonacci/Lucas/Tribonacci/Pell with go/done handshake
//
// Purpose: computes term t(n) (1-based) of the recurrence chosen by mode,
// one new term per clock, with sticky overflow and a wrap or saturate policy.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   go       in   start request, accepted only in IDLE or DONE
//   mode     in   0 Fibonacci, 1 Lucas, 2 Tribonacci, 3 Pell (captured with go)
//   n        in   term index, 1-based; n=0 returns 0 (captured with go)
//   result   out  requested term, valid while done=1
//   overflow out  some term up to t(n) exceeded the result width, valid while done=1
//   busy     out  computation in progress
//   done     out  result valid, held until the next accepted go
module seq_gen #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32,
  parameter bit SATURATE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [1:0]              mode,
  input  logic [INPUT_WIDTH-1:0]  n,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [1:0]              mode_r;
  logic [INPUT_WIDTH-1:0]  n_r;
  logic [INPUT_WIDTH-1:0]  idx;
  // r0 = t(idx), r1 = t(idx-1), r2 = t(idx-2)
  logic [OUTPUT_WIDTH-1:0] r0, r1, r2;
  logic                    ovf_acc;

  logic                    accept;
  logic                    finish;
  logic                    step;
  logic [INPUT_WIDTH-1:0]  base;
  logic [OUTPUT_WIDTH+1:0] sum;
  logic                    ovf_nx;
  logic [OUTPUT_WIDTH-1:0] term;
  logic [OUTPUT_WIDTH-1:0] final_val;

  assign base   = (mode_r == 2'd2) ? INPUT_WIDTH'(3) : INPUT_WIDTH'(2);
  assign accept = go && ((state == IDLE) || (state == DONE));
  assign finish = (state == CALC) && ((n_r <= base) || (idx == n_r));
  assign step   = (state == CALC) && !finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (go) state_nx = CALC;
      CALC: begin
        busy = 1'b1;
        if (finish) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (go) state_nx = CALC;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Two spare carry bits hold the worst case 3*(2^W-1) of the Tribonacci sum.
  always_comb begin
    sum = '0;
    case (mode_r)
      2'd2:    sum = {2'b00, r0} + {2'b00, r1} + {2'b00, r2};
      2'd3:    sum = {1'b0, r0, 1'b0} + {2'b00, r1};
      default: sum = {2'b00, r0} + {2'b00, r1};
    endcase
  end

  assign ovf_nx = ovf_acc || (sum[OUTPUT_WIDTH+1:OUTPUT_WIDTH] != 2'b00);
  assign term   = (SATURATE && ovf_nx) ? '1 : sum[OUTPUT_WIDTH-1:0];

  // For n <= base no iteration happens; pick the seed whose index matches n.
  always_comb begin
    final_val = r0;
    if (n_r == '0)                           final_val = '0;
    else if (n_r >= base)                    final_val = r0;
    else if ((base - n_r) == INPUT_WIDTH'(1)) final_val = r1;
    else                                     final_val = r2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r   <= '0;
      n_r      <= '0;
      idx      <= '0;
      r0       <= '0;
      r1       <= '0;
      r2       <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      mode_r   <= mode;
      n_r      <= n;
      ovf_acc  <= 1'b0;
      overflow <= 1'b0;
      r0       <= OUTPUT_WIDTH'(1);
      r1       <= (mode == 2'd1) ? OUTPUT_WIDTH'(2) : '0;
      r2       <= '0;
      idx      <= (mode == 2'd2) ? INPUT_WIDTH'(3) : INPUT_WIDTH'(2);
    end else if (step) begin
      r2      <= r1;
      r1      <= r0;
      r0      <= term;
      ovf_acc <= ovf_nx;
      idx     <= idx + INPUT_WIDTH'(1);
    end else if (finish) begin
      result   <= final_val;
      overflow <= ovf_acc;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - self-checking bench for seq_gen, wrap and saturate instances
module tb_seq_gen;

  localparam int IW = 6;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [1:0]    mode;
  logic [IW-1:0] n;
  logic [OW-1:0] res_w, res_s;
  logic          ovf_w, ovf_s, busy_w, busy_s, done_w, done_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_gen #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .n(n),
    .result(res_w), .overflow(ovf_w), .busy(busy_w), .done(done_w)
  );

  seq_gen #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .n(n),
    .result(res_s), .overflow(ovf_s), .busy(busy_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: builds the whole term list from the sequence definitions.
  task automatic model(input int m, input int nn, input bit sat,
                       output longint unsigned res, output bit ovf);
    longint unsigned t[0:70];
    longint unsigned mask = (64'd1 << OW) - 1;
    longint unsigned v;
    int b = (m == 2) ? 3 : 2;
    ovf = 1'b0;
    t[0] = 0;
    for (int k = 1; k <= nn; k++) begin
      if (k <= b) begin
        case (m)
          1:       t[k] = (k == 1) ? 2 : 1;
          2:       t[k] = (k == 3) ? 1 : 0;
          default: t[k] = (k == 2) ? 1 : 0;
        endcase
      end else begin
        case (m)
          2:       v = t[k-1] + t[k-2] + t[k-3];
          3:       v = 2 * t[k-1] + t[k-2];
          default: v = t[k-1] + t[k-2];
        endcase
        if (v > mask) ovf = 1'b1;
        t[k] = (sat && ovf) ? mask : (v & mask);
      end
    end
    res = (nn == 0) ? 0 : t[nn];
  endtask

  task automatic launch(input int m, input int nn);
    @(negedge clk);
    go   = 1'b1;
    mode = 2'(m);
    n    = IW'(nn);
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  // Waits for done, counting edges since the accepting edge; exp_const < 0 skips the constant check.
  task automatic finish_req(input string tag, input int m, input int nn,
                            input int already, input longint exp_const);
    longint unsigned rw, rs;
    bit ow, os;
    int b = (m == 2) ? 3 : 2;
    int lat = 1 + ((nn > b) ? nn - b : 0);
    int edges = already;
    model(m, nn, 1'b0, rw, ow);
    model(m, nn, 1'b1, rs, os);
    while (!done_w && edges < 200) begin
      check({tag, ".busy"}, busy_w, 1'b1);
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, ".done"}, done_w, 1'b1);
    check({tag, ".lat"}, edges, lat);
    check({tag, ".busy_at_done"}, busy_w, 1'b0);
    check({tag, ".res"}, res_w, rw);
    check({tag, ".ovf"}, ovf_w, ow);
    check({tag, ".done_sat"}, done_s, 1'b1);
    check({tag, ".res_sat"}, res_s, rs);
    check({tag, ".ovf_sat"}, ovf_s, os);
    if (exp_const >= 0) check({tag, ".const"}, res_w, exp_const);
  endtask

  task automatic req(input string tag, input int m, input int nn, input longint exp_const);
    launch(m, nn);
    finish_req(tag, m, nn, 0, exp_const);
  endtask

  int dcnt;

  initial begin
    rst  = 1'b0;
    go   = 1'b0;
    mode = 2'd0;
    n    = '0;
    #12;
    check("rst.result", res_w, 0);
    check("rst.overflow", ovf_w, 0);
    check("rst.busy", busy_w, 0);
    check("rst.done", done_w, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle.busy", busy_w, 0);

    req("fib10", 0, 10, 34);
    req("luc1", 1, 1, 2);
    req("luc5", 1, 5, 7);
    req("pell6", 3, 6, 29);
    req("trib10", 2, 10, 44);
    req("trib0", 2, 0, 0);
    req("fib48", 0, 48, 64'd2971215073);
    req("fib49", 0, 49, 64'd512559680);
    check("fib49.sat_const", res_s, 64'hFFFF_FFFF);
    check("fib49.ovf_const", ovf_w, 1'b1);
    req("fib5", 0, 5, 3);
    check("fib5.ovf_clear", ovf_s, 1'b0);

    // go while busy is ignored
    launch(0, 20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    go   = 1'b1;
    n    = IW'(3);
    mode = 2'd1;
    @(posedge clk);
    #1;
    go = 1'b0;
    finish_req("ign20", 0, 20, 3, 4181);
    launch(0, 3);
    check("relaunch.done_clr", done_w, 1'b0);
    finish_req("fib3", 0, 3, 0, 1);

    // go held high: done pulses for exactly one cycle per request
    @(negedge clk);
    go   = 1'b1;
    mode = 2'd0;
    n    = IW'(2);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("held.done", done_w, (i % 2) == 1);
      check("held.excl", done_w & busy_w, 1'b0);
      if (done_w) dcnt++;
    end
    check("held.count", dcnt, 4);
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(posedge clk);

    // reset mid-computation
    launch(0, 40);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst.result", res_w, 0);
    check("arst.done", done_w, 0);
    check("arst.busy", busy_w, 0);
    check("arst.ovf", ovf_w, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("arst.idle", {busy_w, done_w, res_w}, '0);
    end
    req("fib7", 0, 7, 8);

    // randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      req("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
